// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: owns the HI/LO register pair beside the EX-stage ALU.
// multu and divu run on an iterative engine that retires one bit per cycle
// over 32 cycles. A stall request freezes IF/ID/EX while the engine works.
// mthi/mtlo are single-cycle writes taken only while the engine is idle.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-low
//   start        EX holds an HI/LO-class instruction this cycle
//   op           00 multu, 01 divu, 10 mthi, 11 mtlo
//   a, b         rs / rt operands
//   cancel       pipeline flush; aborts an in-flight operation
//   stall_req    combinational freeze request to hazard control
//   busy         iteration in progress
//   done         one-cycle pulse; hi/lo hold the new result
//   div_by_zero  last completed divu had b == 0 (cleared by the next accept)
//   hi, lo       HI / LO registers
//
// state  | meaning
// S_IDLE | no operation in flight; accepts multu/divu/mthi/mtlo
// S_MUL  | shift-add multiply iteration
// S_DIV  | restoring divide iteration
module hilo_md_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cancel,
  output logic              stall_req,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  // acc: product high half (multu) or partial remainder (divu).
  // q:   multiplier shifting out / product low half (multu),
  //      dividend shifting out / quotient shifting in (divu).
  logic [DATA_W-1:0] acc, q, opnd;
  logic [DATA_W-1:0] acc_step, q_step;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W-1:0] div_diff;
  logic              div_ge;
  logic              accept, move_wr, last, finish;

  assign busy      = (state != S_IDLE);
  // done gates the accept so the instruction still sitting in EX during the
  // done cycle does not launch a second operation.
  assign accept    = (state == S_IDLE) & start & ~cancel & ~done & ~op[1];
  assign move_wr   = (state == S_IDLE) & start & ~cancel & op[1];
  assign last      = (cnt == CNT_W'(DATA_W - 1));
  assign stall_req = busy | (start & ~op[1] & ~done & ~cancel);

  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = op[0] ? S_DIV : S_MUL;
      end
      S_MUL, S_DIV: begin
        if (cancel) begin
          state_nxt = S_IDLE;
        end else if (last) begin
          state_nxt = S_IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One iteration of either engine. With b == 0 the divide compare always
  // succeeds, so the quotient fills with ones and the remainder ends as a.
  always_comb begin
    mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, opnd} : '0);
    div_shift = {acc, q[DATA_W-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[DATA_W-1:0] - opnd;
    if (state == S_DIV) begin
      acc_step = div_ge ? div_diff : div_shift[DATA_W-1:0];
      q_step   = {q[DATA_W-2:0], div_ge};
    end else begin
      acc_step = mul_sum[DATA_W:1];
      q_step   = {mul_sum[0], q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      acc         <= '0;
      q           <= '0;
      opnd        <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        acc         <= '0;
        q           <= a;
        opnd        <= b;
        cnt         <= '0;
        div_by_zero <= 1'b0;
      end else if (busy && !cancel) begin
        acc <= acc_step;
        q   <= q_step;
        cnt <= cnt + CNT_W'(1);
      end
      if (finish) begin
        hi <= acc_step;
        lo <= q_step;
        if (state == S_DIV) div_by_zero <= (opnd == '0);
      end
      if (move_wr) begin
        if (op[0]) lo <= a;
        else       hi <= a;
      end
    end
  end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
module tb_hilo_md_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        stall_req, busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  // Reference model state: architectural HI/LO and the divide-by-zero flag.
  logic [31:0] hi_m, lo_m;
  logic        dbz_m;

  hilo_md_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .stall_req(stall_req), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_hi"}, hi, hi_m);
    chk({tag, "_lo"}, lo, lo_m);
    chk({tag, "_dbz"}, div_by_zero, dbz_m);
  endtask

  // multu/divu issued now (caller sits between negedge and posedge), start
  // held until the instruction leaves EX one edge after the done cycle.
  // With inj set, an mthi is presented at busy cycle 5 and must be ignored.
  task automatic mdop(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                      input bit inj);
    int bcyc, scyc;
    logic [63:0] p;
    logic [31:0] r_hi, r_lo;
    logic        r_dbz;
    p = {32'b0, av} * {32'b0, bv};
    if (o == 2'b00) begin
      r_hi = p[63:32]; r_lo = p[31:0]; r_dbz = 1'b0;
    end else if (bv == 0) begin
      r_hi = av; r_lo = 32'hFFFF_FFFF; r_dbz = 1'b1;
    end else begin
      r_hi = av % bv; r_lo = av / bv; r_dbz = 1'b0;
    end
    start = 1'b1; op = o; a = av; b = bv; cancel = 1'b0;
    #1;
    chk("accept_stall", stall_req, 1);
    chk("accept_busy", busy, 0);
    scyc = 1; bcyc = 0;
    for (int g = 0; g < 40; g++) begin
      @(negedge clk); #1;
      if (done) break;
      bcyc += int'(busy);
      scyc += int'(stall_req);
      if (bcyc == 1) begin
        chk("busy1_dbz_clear", div_by_zero, 0);
        chk("busy1_hi_hold", hi, hi_m);
        chk("busy1_lo_hold", lo, lo_m);
      end
      if (inj && bcyc == 5) begin
        op = 2'b10; a = 32'hCAFE_F00D;
      end else if (inj && bcyc == 6) begin
        op = o; a = av;
      end
    end
    hi_m = r_hi; lo_m = r_lo; dbz_m = r_dbz;
    chk("done_seen", done, 1);
    chk("busy_cycles", bcyc, 32);
    chk("stall_cycles", scyc, 33);
    chk("done_stall", stall_req, 0);
    chk("done_busy", busy, 0);
    chk_regs("result");
    @(negedge clk); #1;
    start = 1'b0;
    #1;
    chk("post_done_pulse", done, 0);
    chk("post_no_relaunch", busy, 0);
    chk("post_stall", stall_req, 0);
    chk_regs("post");
  endtask

  task automatic mv(input logic [1:0] o, input logic [31:0] av);
    start = 1'b1; op = o; a = av; cancel = 1'b0;
    #1;
    chk("mv_stall", stall_req, 0);
    @(negedge clk); #1;
    if (o[0]) lo_m = av;
    else      hi_m = av;
    chk_regs("mv");
    chk("mv_busy", busy, 0);
    chk("mv_done", done, 0);
  endtask

  task automatic cancel_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                           input int at);
    start = 1'b1; op = o; a = av; b = bv; cancel = 1'b0;
    for (int i = 0; i < at; i++) begin
      @(negedge clk); #1;
    end
    dbz_m = 1'b0;
    chk("cancel_pre_busy", busy, 1);
    cancel = 1'b1;
    @(negedge clk); #1;
    chk("cancel_busy", busy, 0);
    chk("cancel_done", done, 0);
    chk_regs("cancel");
    cancel = 1'b0; start = 1'b0;
    #1;
    chk("cancel_stall", stall_req, 0);
  endtask

  initial begin
    logic [31:0] av, bv;
    int r;
    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; cancel = 1'b0;
    hi_m = '0; lo_m = '0; dbz_m = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall_req, 0);
    chk_regs("rst");
    rst = 1'b1;
    @(negedge clk); #1;

    mdop(2'b00, 32'h0001_0000, 32'h0001_0000, 1'b0);
    mdop(2'b01, 32'd100, 32'd7, 1'b0);
    mdop(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    mdop(2'b01, 32'h0000_1234, 32'd0, 1'b0);
    mdop(2'b00, 32'd3, 32'd5, 1'b0);

    mv(2'b10, 32'hDEAD_BEEF);
    mv(2'b11, 32'h1234_5678);
    start = 1'b0;
    @(negedge clk); #1;

    mdop(2'b01, 32'h8765_4321, 32'h0000_0013, 1'b1);

    cancel_op(2'b01, 32'hFFFF_0000, 32'd9, 10);
    mdop(2'b00, 32'h0000_ABCD, 32'h0001_0001, 1'b0);

    // Reset mid-operation at busy cycle 20.
    start = 1'b1; op = 2'b00; a = 32'h1357_9BDF; b = 32'h2468_ACE0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
    end
    chk("rstmid_pre_busy", busy, 1);
    rst = 1'b0;
    @(negedge clk); #1;
    hi_m = '0; lo_m = '0; dbz_m = 1'b0;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk_regs("rstmid");
    start = 1'b0;
    #1;
    chk("rstmid_stall", stall_req, 0);
    rst = 1'b1;
    @(negedge clk); #1;

    for (int k = 0; k < 24; k++) begin
      r  = int'($urandom_range(0, 3));
      av = $urandom;
      case ($urandom_range(0, 3))
        0:       bv = 32'd0;
        1:       bv = $urandom_range(1, 255);
        default: bv = $urandom;
      endcase
      if (r < 2) mdop(2'(r), av, bv, 1'b0);
      else       mv(2'(r), av);
    end
    start = 1'b0;
    @(negedge clk); #1;
    chk("end_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
